// File: rtl/seq_gen_pkg.sv
// Shared types and helpers for the seq_gen serial pattern transmitter.
// Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit to every frame.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic IDLE_VAL_DEF = 1'b0;

  // Bits per transmitted frame, including the parity slot when enabled.
  function automatic int frame_w(input int pat_w);
`ifdef SEQ_GEN_PARITY_EN
    return pat_w + 1;
`else
    return pat_w;
`endif
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable MSB-first shift register with frame bit counter and last-bit flag.
// With SEQ_GEN_PARITY_EN an even-parity accumulator supplies the extra frame bit.
module seq_gen_shreg
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PAT_W-1:0] i_data,
  output logic             o_nxt_bit,
  output logic             o_last
);

  localparam int FRAME_W = frame_w(PAT_W);
  localparam int CW      = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic             w_bit;
  logic             w_shift_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_sh  <= i_data;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sh  <= {r_sh[PAT_W-2:0], 1'b0};
      r_cnt <= r_cnt + CW'(1);
    end
  end

`ifdef SEQ_GEN_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par <= 1'b0;
    end else if (i_load) begin
      r_par <= 1'b0;
    end else if (i_shift) begin
      r_par <= r_par ^ r_sh[PAT_W-1];
    end
  end

  assign w_bit       = (r_cnt == CW'(PAT_W)) ? r_par : r_sh[PAT_W-1];
  // After the LSB shifts out, the next slot carries the completed parity.
  assign w_shift_bit = (r_cnt == CW'(PAT_W - 1)) ? (r_par ^ r_sh[PAT_W-1]) : r_sh[PAT_W-2];
`else
  assign w_bit       = r_sh[PAT_W-1];
  assign w_shift_bit = r_sh[PAT_W-2];
`endif

  // Bit that will be presented after the coming edge; lets the top register dout.
  always_comb begin
    o_nxt_bit = w_bit;
    if (i_load) begin
      o_nxt_bit = i_data[PAT_W-1];
    end else if (i_shift) begin
      o_nxt_bit = w_shift_bit;
    end
  end

  assign o_last = (r_cnt == CW'(FRAME_W - 1));

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first, reps times, with GAP idle cycles between.
// Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit after each frame's LSB.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int   PAT_W    = 8,
  parameter int   REP_W    = 4,
  parameter int   GAP      = 1,
  parameter logic IDLE_VAL = IDLE_VAL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             ready,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           r_state;
  state_t           w_nxt_state;
  logic [PAT_W-1:0] r_shadow;
  logic [REP_W-1:0] r_rem;
  logic [GW-1:0]    r_gap;
  logic             w_accept;
  logic             w_reload;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_nxt_bit;
  logic [PAT_W-1:0] w_ld_data;

  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_reload    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_accept    = 1'b1;
          w_nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_nxt_state = IDLE;
        end else if (w_last) begin
          if (r_rem > REP_W'(1)) begin
            w_reload    = 1'b1;
            w_nxt_state = (GAP > 0) ? GAPW : SHIFT;
          end else begin
            w_nxt_state = DONE;
          end
        end
      end
      GAPW: begin
        if (abort) begin
          w_nxt_state = IDLE;
        end else if (r_gap == '0) begin
          w_nxt_state = SHIFT;
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  assign w_load    = w_accept | w_reload;
  assign w_shift   = (r_state == SHIFT) && !w_last;
  assign w_ld_data = w_accept ? pattern : r_shadow;

  seq_gen_shreg #(
    .PAT_W(PAT_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_shift  (w_shift),
    .i_data   (w_ld_data),
    .o_nxt_bit(w_nxt_bit),
    .o_last   (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_rem    <= '0;
      r_gap    <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_accept) begin
        r_shadow <= pattern;
        r_rem    <= (reps == '0) ? REP_W'(1) : reps;
      end else if (w_reload) begin
        r_rem <= r_rem - REP_W'(1);
      end
      if (w_reload) begin
        r_gap <= GW'((GAP > 0) ? GAP - 1 : 0);
      end else if (r_state == GAPW && r_gap != '0) begin
        r_gap <= r_gap - GW'(1);
      end
    end
  end

  // Outputs are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout_vld <= 1'b0;
      dout     <= IDLE_VAL;
    end else begin
      ready    <= (w_nxt_state == IDLE);
      busy     <= (w_nxt_state == SHIFT) || (w_nxt_state == GAPW);
      done     <= (w_nxt_state == DONE);
      dout_vld <= (w_nxt_state == SHIFT);
      dout     <= (w_nxt_state == SHIFT) ? w_nxt_bit : IDLE_VAL;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed, table-driven bench for seq_gen (GAP=2 instance plus a GAP=0 instance).
module tb_seq_gen;
  import seq_gen_pkg::*;

  localparam int PAT_W = 8;
  localparam int REP_W = 4;
  localparam int GAP   = 2;
  localparam int FW    = frame_w(PAT_W);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             start0 = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [REP_W-1:0] reps = '0;
  logic ready, dout, dout_vld, busy, done;
  logic ready0, dout0, dout_vld0, busy0, done0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP(GAP), .IDLE_VAL(1'b0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps), .abort(abort),
    .ready(ready), .dout(dout), .dout_vld(dout_vld), .busy(busy), .done(done)
  );

  seq_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP(0), .IDLE_VAL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pattern), .reps(reps), .abort(abort),
    .ready(ready0), .dout(dout0), .dout_vld(dout_vld0), .busy(busy0), .done(done0)
  );

  // Reference sequence detector for 1011 on the valid bit stream.
  logic [3:0] det_sh;
  logic       det_hit;
  logic       det_clr = 1'b1;
  always @(posedge clk) begin
    if (det_clr) begin
      det_sh  <= 4'd0;
      det_hit <= 1'b0;
    end else if (dout_vld) begin
      det_sh <= {det_sh[2:0], dout};
      if ({det_sh[2:0], dout} == 4'b1011) det_hit <= 1'b1;
    end
  end

  typedef struct {
    logic [PAT_W-1:0] pat;
    logic [REP_W-1:0] reps;
    int               done_cyc;
    int               n_vld;
    bit               det;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [4:0] obs();
    return {ready, busy, done, dout_vld, dout};
  endfunction

  function automatic logic [4:0] obs0();
    return {ready0, busy0, done0, dout_vld0, dout0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && !ready; i++) @(negedge clk);
    chk("wait ready", 32'(ready), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int         per, t, k, nv;
    logic       e_vld, e_bit;
    logic [4:0] e;
    per = FW + GAP;
    nv  = 0;
    wait_ready();
    @(negedge clk);
    pattern = v.pat;
    reps    = v.reps;
    start   = 1'b1;
    det_clr = 1'b1;
    for (int c = 1; c <= v.done_cyc + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start   = 1'b0;
        det_clr = 1'b0;
        pattern = ~v.pat;
        reps    = '0;
      end
      t     = c - 1;
      k     = t % per;
      e_vld = (c < v.done_cyc) && (k < FW);
      e_bit = e_vld ? ((k < PAT_W) ? v.pat[PAT_W-1-k] : ^v.pat) : 1'b0;
      e     = {(c == v.done_cyc + 1), (c < v.done_cyc), (c == v.done_cyc), e_vld, e_bit};
      chk($sformatf("vec %0h x%0d cyc %0d {rdy,bsy,dn,vld,dout}", v.pat, v.reps, c), 32'(obs()), 32'(e));
      if (dout_vld) nv++;
    end
    chk($sformatf("vec %0h valid count", v.pat), 32'(nv), 32'(v.n_vld));
    chk($sformatf("vec %0h detector", v.pat), 32'(det_hit), 32'(v.det));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef SEQ_GEN_PARITY_EN
    tbl[0] = '{8'hB2, 4'd1, 10, 9, 1'b1};
    tbl[1] = '{8'hF0, 4'd3, 32, 27, 1'b0};
    tbl[2] = '{8'h01, 4'd0, 10, 9, 1'b0};
    tbl[3] = '{8'h5A, 4'd2, 21, 18, 1'b1};
    tbl[4] = '{8'h3C, 4'd1, 10, 9, 1'b0};
`else
    tbl[0] = '{8'hB2, 4'd1, 9, 8, 1'b1};
    tbl[1] = '{8'hF0, 4'd3, 29, 24, 1'b0};
    tbl[2] = '{8'h01, 4'd0, 9, 8, 1'b0};
    tbl[3] = '{8'h5A, 4'd2, 19, 16, 1'b1};
    tbl[4] = '{8'h3C, 4'd1, 9, 8, 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk("reset state in reset", 32'(obs()), 32'b10000);
    chk("reset state in reset gap0", 32'(obs0()), 32'b10000);
    rst = 1'b1;
    @(negedge clk);
    chk("reset state after release", 32'(obs()), 32'b10000);

    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // abort mid-frame, with an ignored start while busy
    wait_ready();
    @(negedge clk);
    pattern = 8'hB2;
    reps    = 4'd1;
    start   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin
        pattern = 8'h00;
        reps    = 4'd5;
      end
      chk($sformatf("abort frame cyc %0d", c), 32'(obs()), 32'({4'b0101, tbl[0].pat[PAT_W-c]}));
      if (c == 4) abort = 1'b1;
    end
    for (int c = 5; c <= 16; c++) begin
      @(negedge clk);
      abort = 1'b0;
      chk($sformatf("after abort cyc %0d", c), 32'(obs()), 32'b10000);
    end

    // abort and start together in IDLE: abort wins
    @(negedge clk);
    pattern = 8'hFF;
    reps    = 4'd1;
    start   = 1'b1;
    abort   = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("abort+start idle cyc %0d", c), 32'(obs()), 32'b10000);
    end

    run_vec(tbl[4]);

    // asynchronous reset mid-frame
    wait_ready();
    @(negedge clk);
    pattern = 8'hFF;
    reps    = 4'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset cyc 3", 32'(obs()), 32'b01011);
    #2 rst = 1'b0;
    #1 chk("reset mid-frame immediate", 32'(obs()), 32'b10000);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("after reset cyc %0d", c), 32'(obs()), 32'b10000);
    end

    // back-to-back repeats on the GAP=0 instance
    @(negedge clk);
    pattern = 8'hC5;
    reps    = 4'd2;
    start0  = 1'b1;
    for (int c = 1; c <= 2 * FW + 2; c++) begin
      logic       ev, eb;
      logic [4:0] e;
      int         k;
      @(negedge clk);
      start0 = 1'b0;
      k  = (c - 1) % FW;
      ev = (c <= 2 * FW);
      eb = ev ? ((k < PAT_W) ? pattern[PAT_W-1-k] : ^pattern) : 1'b0;
      e  = {(c == 2 * FW + 2), ev, (c == 2 * FW + 1), ev, eb};
      chk($sformatf("gap0 cyc %0d", c), 32'(obs0()), 32'(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
